// File: rtl/adder_pkg.sv
// Shared adder-path definitions: default widths, accumulator FSM states, result record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_pkg;

  // Default adder sum width and frame length.
  localparam int DEF_WIDTH = 4;
  localparam int DEF_N     = 4;
  // Wide enough for N results of (WIDTH+1) bits each, so a frame total never wraps.
  localparam int DEF_ACC_W = DEF_WIDTH + 1 + $clog2(DEF_N);

  // Accumulator FSM: ACCUM gathers results, HOLD presents a finished frame total.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // One adder result as produced by the adder stage.
  typedef struct packed {
    logic                 carry;
    logic [DEF_WIDTH-1:0] sum;
  } result_t;

endpackage

// File: rtl/adder_sum_accumulator.sv
// Sums N consecutive adder results {carry, sum} into a frame total on a valid/ready port.
// Latency: out_valid rises the cycle after the N-th accepted result; HOLD overlaps next frame's first input.
// Backpressure: while a total is held, in_ready follows out_ready combinationally; out_acc stays frozen.
module adder_sum_accumulator
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int ACC_W = WIDTH + 1 + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [15:0]      out_frames
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_e           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] value;
  logic             in_hs;
  logic             out_hs;

  // Carry becomes the MSB of the result; zero-extend to accumulator width.
  assign value = ACC_W'({in_carry, in_sum});

  // Ready depends only on state and downstream ready, never on in_valid.
  assign in_ready = (state == HOLD) ? out_ready : 1'b1;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  // Frame FSM, running sum, result counter, registered output and frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_frames <= '0;
    end else if (clear) begin
      // Flush wins over both handshakes; out_acc and out_frames keep their values.
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (state == ACCUM) begin
      if (in_hs) begin
        if (cnt == LAST_CNT) begin
          out_acc   <= acc + value;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          state     <= HOLD;
        end else begin
          acc <= acc + value;
          cnt <= cnt + 1'b1;
        end
      end
    end else begin
      // HOLD: a result can only arrive together with the output handshake,
      // and it becomes the first element of the next frame.
      if (out_hs) begin
        out_valid  <= 1'b0;
        out_frames <= out_frames + 16'd1;
        state      <= ACCUM;
        if (in_hs) begin
          acc <= value;
          cnt <= CNT_W'(1);
        end else begin
          acc <= '0;
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: doc/adder_sum_accumulator.md
# adder_sum_accumulator

Downstream consumer of the adder stage. It accepts one adder result per valid/ready handshake, where a result is {carry, sum}. It accumulates N consecutive results into a frame total and presents that total on a valid/ready output port. It sits between the adder and the result checker/scoreboard path and shares the adder's clock and reset.

## Interface
Parameters:
- WIDTH, 4: adder sum width in bits.
- N, 4: number of adder results per frame (N ≥ 2).
- ACC_W, WIDTH+1+$clog2(N): accumulator width; never overflows.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- clear, input, 1: synchronous frame flush, active-high.
- in_valid, input, 1: adder result valid.
- in_ready, output, 1: block can accept a result this cycle.
- in_sum, input, WIDTH: adder sum.
- in_carry, input, 1: adder carry-out.
- out_valid, output, 1: frame total valid.
- out_ready, input, 1: downstream accepts the total.
- out_acc, output, ACC_W: frame total, registered.
- out_frames, output, 16: count of completed output handshakes; wraps at 2^16.

## Operation
- Each result is the zero-extended value {in_carry, in_sum}, taking values 0 to 2^(WIDTH+1)−1.
- Input handshake: in_valid && in_ready.
- Output handshake: out_valid && out_ready.
- FSM has two states, ACCUM and HOLD.
  - ACCUM:
    - in_ready=1, out_valid=0.
    - On each input handshake, acc += value and cnt++.
    - On the handshake with cnt==N−1, out_acc ← acc+value, then acc and cnt reset to 0, and the FSM moves to HOLD.
  - HOLD:
    - out_valid=1, and in_ready=out_ready (combinational pass-through).
    - Output handshake without an input handshake: move to ACCUM with acc=0, cnt=0.
    - Output and input handshakes in the same cycle: move to ACCUM with acc=value, cnt=1.
    - No output handshake: out_acc is held stable and inputs are back-pressured.
- out_frames increments on every output handshake.
- clear:
  - Has priority over all handshakes in the same cycle.
  - Sets acc=0, cnt=0, state=ACCUM, out_valid=0.
  - Any input or output handshake in that cycle is discarded; an input in the clear cycle is not accumulated.
  - Does not modify out_frames.
- Reset mid-frame discards the partial sum. No frame is emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, out_acc=0, out_frames=0, state=ACCUM, acc=0, cnt=0.
- in_ready is 1 from the first cycle after reset deassertion.
- Latency: out_valid rises in the cycle after the N-th input handshake.
- Throughput: one frame per N cycles under continuous valid and ready. The HOLD cycle overlaps with the first input of the next frame.
- out_acc and out_valid are registered. in_ready is combinational from state and out_ready only.
- While out_valid=1 and out_ready=0, out_acc must not change.

## Structure
- Shared package adder_pkg holds:
  - WIDTH, N, ACC_W defaults;
  - state_e enum {ACCUM, HOLD};
  - a result struct {carry, sum}, reused by the adder-side interface.
- Single module. The frame counter and accumulator are inline; there is no sub-module.

## Test plan
All scenarios use WIDTH=4, N=4.
- Reset values: hold rst=0 for 2 cycles, then release. in_ready=1, out_valid=0, out_acc=0, out_frames=0.
- Basic frame: inputs 3, 5, 7, then {carry=1, sum=2}=18 back-to-back, out_ready=1. out_valid=1 for one cycle with out_acc=33, then out_frames=1.
- Maximum value: four inputs of {1, 15}=31. out_acc=124, with no overflow in 7 bits.
- Back-pressure: complete a frame, hold out_ready=0 for 5 cycles with in_valid=1. in_ready=0, out_acc is stable, and nothing is accepted. Then raise out_ready: the output handshake and the first new input occur in the same cycle, and the new frame starts at that input value.
- Clear mid-frame: accept 2 inputs (4, 6), then pulse clear together with in_valid (value 9). Next accept 1, 1, 1, 1. out_acc=4: the 4 and 6 are discarded, and the 9 is not counted.
- Async reset mid-HOLD: assert rst between clock edges while out_valid=1. out_valid=0 immediately, without waiting for a clock edge. After release, a fresh 4-input frame sums correctly.
